spi_cmd_decoder: RTL and testbench

Command-layer stage directly downstream of the SPI slave. It consumes received bytes (RX_BYTE/RX_DONE) and parses framed commands into accesses on the on-chip buffer memory (weights/inputs/results), TPU start pulses and status reads. It feeds reply bytes back to the SPI slave through TX_BYTE/WE. Runs entirely in the inner clock domain.

---
 rtl/spi_cmd_pkg.sv | 35 +++
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_cmd_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM states and
// the layout of the STATUS reply byte.
package spi_cmd_pkg;

   localparam logic [7:0] OP_WRITE  = 8'h01;
   localparam logic [7:0] OP_READ   = 8'h02;
   localparam logic [7:0] OP_START  = 8'h03;
   localparam logic [7:0] OP_STATUS = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ADDR,
      ST_GET_LEN,
      ST_WR_DATA,
      ST_RD_FETCH,
      ST_RD_LOAD,
      ST_RD_WAIT,
      ST_SINK
   } state_t;

   localparam int STAT_READY_BIT = 0;
   localparam int STAT_BUSY_BIT  = 1;
   localparam int STAT_ERR_BIT   = 2;

   // STATUS reply: {5'b0, err, busy, 1'b1}
   function automatic logic [7:0] status_byte(input logic err, input logic busy);
      logic [7:0] s;
      s                 = 8'h00;
      s[STAT_READY_BIT] = 1'b1;
      s[STAT_BUSY_BIT]  = busy;
      s[STAT_ERR_BIT]   = err;
      return s;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for a single level, with a one-cycle pulse on the
// rising edge of the synchronised level.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the asynchronous input through the flop chain and remember the last level
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Command layer behind the SPI slave: parses WRITE/READ/START/STATUS frames
// into buffer-memory accesses, TPU start pulses and reply bytes.
// All strobes are registered, so each one appears the cycle after the
// decision that raises it.
module spi_cmd_decoder
   import spi_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CS,
   input  logic [7:0]            RX_BYTE,
   input  logic                  RX_DONE,
   output logic [7:0]            TX_BYTE,
   output logic                  WE,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [7:0]            MEM_WDATA,
   output logic                  MEM_WE,
   output logic                  MEM_RE,
   input  logic [7:0]            MEM_RDATA,
   output logic                  TPU_START,
   input  logic                  TPU_BUSY,
   output logic                  CMD_ERR
);

   logic cs_s, cs_rise, rx_level, rx_stb;
   // Only the level of CS and the edge of RX_DONE are needed
   logic sync_unused;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_cnt, addr_nxt;
   logic [7:0]            len_cnt, len_nxt;
   logic                  is_rd, is_rd_nxt;
   logic [7:0]            tx_nxt;
   logic                  we_nxt, mwe_nxt, mre_nxt, start_nxt, err_nxt;
   logic [ADDR_WIDTH-1:0] maddr_nxt;
   logic [7:0]            wdata_nxt;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rx (
      .CLK   (CLK),
      .RST   (RST),
      .din   (RX_DONE),
      .level (rx_level),
      .rise  (rx_stb)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .CLK   (CLK),
      .RST   (RST),
      .din   (CS),
      .level (cs_s),
      .rise  (cs_rise)
   );

   assign sync_unused = rx_level ^ cs_rise;

   // Next-state, counter and output decisions; strobes default low, data holds
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_cnt;
      len_nxt   = len_cnt;
      is_rd_nxt = is_rd;
      tx_nxt    = TX_BYTE;
      we_nxt    = 1'b0;
      maddr_nxt = MEM_ADDR;
      wdata_nxt = MEM_WDATA;
      mwe_nxt   = 1'b0;
      mre_nxt   = 1'b0;
      start_nxt = 1'b0;
      err_nxt   = CMD_ERR;

      if (!cs_s) begin
         // Frame ended: abandon whatever was about to be issued, keep the error flag
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rx_stb) begin
                  case (RX_BYTE)
                     OP_WRITE: begin
                        is_rd_nxt = 1'b0;
                        state_nxt = ST_GET_ADDR;
                     end
                     OP_READ: begin
                        is_rd_nxt = 1'b1;
                        state_nxt = ST_GET_ADDR;
                     end
                     OP_START: begin
                        if (TPU_BUSY) err_nxt   = 1'b1;
                        else          start_nxt = 1'b1;
                        state_nxt = ST_SINK;
                     end
                     OP_STATUS: begin
                        tx_nxt    = status_byte(CMD_ERR, TPU_BUSY);
                        we_nxt    = 1'b1;
                        err_nxt   = 1'b0;
                        state_nxt = ST_SINK;
                     end
                     default: begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_SINK;
                     end
                  endcase
               end
            end
            ST_GET_ADDR: begin
               if (rx_stb) begin
                  addr_nxt  = ADDR_WIDTH'(RX_BYTE);
                  state_nxt = ST_GET_LEN;
               end
            end
            ST_GET_LEN: begin
               if (rx_stb) begin
                  len_nxt = RX_BYTE;
                  if (RX_BYTE == 8'd0) begin
                     state_nxt = ST_SINK;
                  end else if (is_rd) begin
                     maddr_nxt = addr_cnt;
                     mre_nxt   = 1'b1;
                     state_nxt = ST_RD_FETCH;
                  end else begin
                     state_nxt = ST_WR_DATA;
                  end
               end
            end
            ST_WR_DATA: begin
               if (rx_stb) begin
                  maddr_nxt = addr_cnt;
                  wdata_nxt = RX_BYTE;
                  mwe_nxt   = 1'b1;
                  addr_nxt  = addr_cnt + ADDR_WIDTH'(1);
                  len_nxt   = len_cnt - 8'd1;
                  if (len_cnt == 8'd1) state_nxt = ST_SINK;
               end
            end
            ST_RD_FETCH: begin
               // MEM_RE is high during this state; data returns next cycle
               if (rx_stb) err_nxt = 1'b1;
               state_nxt = ST_RD_LOAD;
            end
            ST_RD_LOAD: begin
               if (rx_stb) err_nxt = 1'b1;
               tx_nxt    = MEM_RDATA;
               we_nxt    = 1'b1;
               addr_nxt  = addr_cnt + ADDR_WIDTH'(1);
               len_nxt   = len_cnt - 8'd1;
               state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               // The master's dummy byte has shifted the reply out
               if (rx_stb) begin
                  if (len_cnt == 8'd0) begin
                     state_nxt = ST_SINK;
                  end else begin
                     maddr_nxt = addr_cnt;
                     mre_nxt   = 1'b1;
                     state_nxt = ST_RD_FETCH;
                  end
               end
            end
            ST_SINK: begin
               state_nxt = ST_SINK;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Register state, counters and every output
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         addr_cnt  <= '0;
         len_cnt   <= 8'd0;
         is_rd     <= 1'b0;
         TX_BYTE   <= 8'd0;
         WE        <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= 8'd0;
         MEM_WE    <= 1'b0;
         MEM_RE    <= 1'b0;
         TPU_START <= 1'b0;
         CMD_ERR   <= 1'b0;
      end else begin
         state     <= state_nxt;
         addr_cnt  <= addr_nxt;
         len_cnt   <= len_nxt;
         is_rd     <= is_rd_nxt;
         TX_BYTE   <= tx_nxt;
         WE        <= we_nxt;
         MEM_ADDR  <= maddr_nxt;
         MEM_WDATA <= wdata_nxt;
         MEM_WE    <= mwe_nxt;
         MEM_RE    <= mre_nxt;
         TPU_START <= start_nxt;
         CMD_ERR   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: a scoreboard of expected memory
// writes and reply bytes is filled as frames are sent and drained by a
// monitor as the DUT produces strobes.
module tb_spi_cmd_decoder;
   import spi_cmd_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       CS = 1'b0;
   logic [7:0] RX_BYTE = 8'h00;
   logic       RX_DONE = 1'b0;
   logic       TPU_BUSY = 1'b0;
   logic [7:0] MEM_RDATA = 8'h00;
   logic [7:0] TX_BYTE;
   logic       WE;
   logic [7:0] MEM_ADDR;
   logic [7:0] MEM_WDATA;
   logic       MEM_WE;
   logic       MEM_RE;
   logic       TPU_START;
   logic       CMD_ERR;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_tx[$];
   logic [7:0] mem [0:255];

   int n_checks = 0;
   int n_errors = 0;
   int n_wr = 0;
   int n_re = 0;
   int n_we = 0;
   int n_start = 0;

   spi_cmd_decoder #(.ADDR_WIDTH(8), .SYNC_STAGES(2)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CS        (CS),
      .RX_BYTE   (RX_BYTE),
      .RX_DONE   (RX_DONE),
      .TX_BYTE   (TX_BYTE),
      .WE        (WE),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_WDATA (MEM_WDATA),
      .MEM_WE    (MEM_WE),
      .MEM_RE    (MEM_RE),
      .MEM_RDATA (MEM_RDATA),
      .TPU_START (TPU_START),
      .TPU_BUSY  (TPU_BUSY),
      .CMD_ERR   (CMD_ERR)
   );

   always #5 CLK = ~CLK;

   // Buffer memory model: read data one cycle after MEM_RE
   always @(posedge CLK) begin
      if (MEM_RE) MEM_RDATA <= mem[MEM_ADDR];
   end

   // Scoreboard monitor: pops expectations when the DUT strobes
   always @(negedge CLK) begin
      if (!RST) begin
         if (MEM_WE || MEM_RE || WE || TPU_START) begin
            n_checks++;
            if (int'(MEM_WE) + int'(MEM_RE) + int'(WE) + int'(TPU_START) > 1) begin
               n_errors++;
               $display("FAIL strobe_exclusive: got MEM_WE=%b MEM_RE=%b WE=%b TPU_START=%b, required at most one high",
                        MEM_WE, MEM_RE, WE, TPU_START);
            end
         end
         if (MEM_WE) begin
            n_wr++;
            n_checks++;
            if (exp_wr.size() == 0) begin
               n_errors++;
               $display("FAIL mem_write: got unexpected write addr=%h data=%h, required none", MEM_ADDR, MEM_WDATA);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               if ({MEM_ADDR, MEM_WDATA} !== {e.addr, e.data}) begin
                  n_errors++;
                  $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                           MEM_ADDR, MEM_WDATA, e.addr, e.data);
               end
            end
         end
         if (WE) begin
            n_we++;
            n_checks++;
            if (exp_tx.size() == 0) begin
               n_errors++;
               $display("FAIL tx_byte: got unexpected WE with TX_BYTE=%h, required none", TX_BYTE);
            end else begin
               logic [7:0] t;
               t = exp_tx.pop_front();
               if (TX_BYTE !== t) begin
                  n_errors++;
                  $display("FAIL tx_byte: got %h, required %h", TX_BYTE, t);
               end
            end
         end
         if (MEM_RE) n_re++;
         if (TPU_START) n_start++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      RX_BYTE = b;
      RX_DONE = 1'b1;
      repeat (4) @(negedge CLK);
      RX_DONE = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic cs_on();
      @(negedge CLK);
      CS = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic cs_off();
      @(negedge CLK);
      CS = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   task automatic test_reset();
      #1 RST = 1'b1;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({TX_BYTE, WE, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, TPU_START, CMD_ERR} !== 29'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {TX_BYTE, WE, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, TPU_START, CMD_ERR});
      end
      n_checks++;
      if (dut.state !== ST_IDLE) begin
         n_errors++;
         $display("FAIL reset_state: got %0d, required %0d", dut.state, ST_IDLE);
      end
      RST = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_write();
      int w0;
      w0 = n_wr;
      exp_wr.push_back('{8'h10, 8'hAA});
      exp_wr.push_back('{8'h11, 8'hBB});
      exp_wr.push_back('{8'h12, 8'hCC});
      cs_on();
      send_byte(8'h01); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      cs_off();
      n_checks++;
      if (n_wr - w0 !== 3) begin
         n_errors++;
         $display("FAIL write_count: got %0d, required 3", n_wr - w0);
      end
      n_checks++;
      if (exp_wr.size() !== 0) begin
         n_errors++;
         $display("FAIL write_pending: got %0d outstanding, required 0", exp_wr.size());
      end
      n_checks++;
      if (CMD_ERR !== 1'b0) begin
         n_errors++;
         $display("FAIL write_err: got %b, required 0", CMD_ERR);
      end
   endtask

   task automatic test_read();
      int t0;
      t0 = n_we;
      mem[8'h20] = 8'h11;
      mem[8'h21] = 8'h22;
      exp_tx.push_back(8'h11);
      exp_tx.push_back(8'h22);
      cs_on();
      send_byte(8'h02); send_byte(8'h20); send_byte(8'h02);
      send_byte(8'h00); send_byte(8'h00);
      cs_off();
      n_checks++;
      if (n_we - t0 !== 2) begin
         n_errors++;
         $display("FAIL read_we_count: got %0d, required 2", n_we - t0);
      end
      n_checks++;
      if (exp_tx.size() !== 0) begin
         n_errors++;
         $display("FAIL read_pending: got %0d outstanding, required 0", exp_tx.size());
      end
      n_checks++;
      if (CMD_ERR !== 1'b0) begin
         n_errors++;
         $display("FAIL read_err: got %b, required 0", CMD_ERR);
      end
   endtask

   task automatic test_start_status();
      int s0;
      s0 = n_start;
      TPU_BUSY = 1'b0;
      cs_on(); send_byte(8'h03); cs_off();
      n_checks++;
      if (n_start - s0 !== 1) begin
         n_errors++;
         $display("FAIL start_idle_pulses: got %0d, required 1", n_start - s0);
      end
      n_checks++;
      if (CMD_ERR !== 1'b0) begin
         n_errors++;
         $display("FAIL start_idle_err: got %b, required 0", CMD_ERR);
      end
      s0 = n_start;
      TPU_BUSY = 1'b1;
      cs_on(); send_byte(8'h03); cs_off();
      n_checks++;
      if (n_start - s0 !== 0) begin
         n_errors++;
         $display("FAIL start_busy_pulses: got %0d, required 0", n_start - s0);
      end
      n_checks++;
      if (CMD_ERR !== 1'b1) begin
         n_errors++;
         $display("FAIL start_busy_err: got %b, required 1", CMD_ERR);
      end
      exp_tx.push_back(8'h07);
      cs_on(); send_byte(8'h04); cs_off();
      n_checks++;
      if (exp_tx.size() !== 0) begin
         n_errors++;
         $display("FAIL status_pending: got %0d outstanding, required 0", exp_tx.size());
      end
      n_checks++;
      if (CMD_ERR !== 1'b0) begin
         n_errors++;
         $display("FAIL status_clear: got %b, required 0", CMD_ERR);
      end
      TPU_BUSY = 1'b0;
   endtask

   task automatic test_bad_opcode();
      int w0, r0, t0, s0;
      w0 = n_wr; r0 = n_re; t0 = n_we; s0 = n_start;
      cs_on();
      send_byte(8'h7F); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      cs_off();
      n_checks++;
      if (CMD_ERR !== 1'b1) begin
         n_errors++;
         $display("FAIL bad_op_err: got %b, required 1", CMD_ERR);
      end
      n_checks++;
      if ((n_wr - w0) + (n_re - r0) + (n_we - t0) + (n_start - s0) !== 0) begin
         n_errors++;
         $display("FAIL bad_op_activity: got %0d strobes, required 0",
                  (n_wr - w0) + (n_re - r0) + (n_we - t0) + (n_start - s0));
      end
      n_checks++;
      if (dut.state !== ST_IDLE) begin
         n_errors++;
         $display("FAIL bad_op_idle: got %0d, required %0d", dut.state, ST_IDLE);
      end
      exp_wr.push_back('{8'h30, 8'h5A});
      cs_on(); send_byte(8'h01); send_byte(8'h30); send_byte(8'h01); send_byte(8'h5A); cs_off();
      n_checks++;
      if (exp_wr.size() !== 0) begin
         n_errors++;
         $display("FAIL after_bad_write: got %0d outstanding, required 0", exp_wr.size());
      end
      exp_tx.push_back(8'h05);
      cs_on(); send_byte(8'h04); cs_off();
      n_checks++;
      if ({CMD_ERR, 8'(exp_tx.size())} !== 9'd0) begin
         n_errors++;
         $display("FAIL bad_op_status: got err=%b outstanding=%0d, required err=0 outstanding=0",
                  CMD_ERR, exp_tx.size());
      end
   endtask

   task automatic test_cs_abort();
      int w0;
      w0 = n_wr;
      exp_wr.push_back('{8'hFF, 8'hD1});
      cs_on(); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02); send_byte(8'hD1); cs_off();
      n_checks++;
      if (n_wr - w0 !== 1) begin
         n_errors++;
         $display("FAIL abort_write_count: got %0d, required 1", n_wr - w0);
      end
      n_checks++;
      if (dut.state !== ST_IDLE) begin
         n_errors++;
         $display("FAIL abort_idle: got %0d, required %0d", dut.state, ST_IDLE);
      end
      w0 = n_wr;
      exp_wr.push_back('{8'h40, 8'hE7});
      cs_on(); send_byte(8'h01); send_byte(8'h40); send_byte(8'h01); send_byte(8'hE7); cs_off();
      n_checks++;
      if ((n_wr - w0 !== 1) || (exp_wr.size() !== 0)) begin
         n_errors++;
         $display("FAIL abort_next_frame: got %0d writes %0d outstanding, required 1 and 0",
                  n_wr - w0, exp_wr.size());
      end
   endtask

   task automatic test_reset_mid_and_zero_len();
      int r0, t0;
      mem[8'h50] = 8'h77;
      exp_tx.push_back(8'h77);
      cs_on(); send_byte(8'h02); send_byte(8'h50); send_byte(8'h03);
      n_checks++;
      if ({8'(dut.state), MEM_ADDR, TX_BYTE} !== {8'(ST_RD_WAIT), 8'h50, 8'h77}) begin
         n_errors++;
         $display("FAIL pre_reset: got state=%0d addr=%h tx=%h, required state=%0d addr=50 tx=77",
                  dut.state, MEM_ADDR, TX_BYTE, ST_RD_WAIT);
      end
      @(negedge CLK);
      RST = 1'b1;
      #1;
      n_checks++;
      if ({TX_BYTE, WE, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, TPU_START, CMD_ERR} !== 29'd0) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got %h, required 0",
                  {TX_BYTE, WE, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, TPU_START, CMD_ERR});
      end
      n_checks++;
      if (dut.state !== ST_IDLE) begin
         n_errors++;
         $display("FAIL mid_reset_state: got %0d, required %0d", dut.state, ST_IDLE);
      end
      CS = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      r0 = n_re; t0 = n_we;
      cs_on(); send_byte(8'h02); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); cs_off();
      n_checks++;
      if ((n_re - r0) + (n_we - t0) !== 0) begin
         n_errors++;
         $display("FAIL zero_len_read: got %0d MEM_RE %0d WE, required 0 and 0", n_re - r0, n_we - t0);
      end
      n_checks++;
      if (exp_tx.size() !== 0) begin
         n_errors++;
         $display("FAIL zero_len_pending: got %0d outstanding, required 0", exp_tx.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_start_status();
      test_bad_opcode();
      test_cs_abort();
      test_reset_mid_and_zero_len();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
